instr_sequencer: RTL

Parametrised instruction sequencer that replaces hard-coded per-instruction stimulus with a loadable program memory. It holds up to DEPTH instruction words and issues them in order to the processor over the instr/reg1/reg2/reg3/const bus, pacing each issue on the processor's `done` handshake. It sits between the test/host side, which loads the program and pulses `start`, and the processor core.

---
 rtl/instr_sequencer_if.sv | 52 +++++
 rtl/instr_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Brief    : Host/processor bus bundle for instr_sequencer (optional loop_cnt
//            present only when SEQ_LOOP_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int OPW    = 3,
    parameter int REGW   = 5,
    parameter int CONSTW = 16,
    parameter int PCW    = 4
);
    localparam int c_IW = OPW + 3*REGW + CONSTW;

    logic              prog_we;
    logic [PCW-1:0]    prog_addr;
    logic [c_IW-1:0]   prog_data;
    logic [PCW:0]      prog_len;
`ifdef SEQ_LOOP_EN
    logic [7:0]        loop_cnt;
`endif
    logic              start;
    logic              abort;
    logic              done;
    logic [OPW-1:0]    instr;
    logic [REGW-1:0]   reg1;
    logic [REGW-1:0]   reg2;
    logic [REGW-1:0]   reg3;
    logic [CONSTW-1:0] cnst;     // immediate field ("const" is a reserved word)
    logic              issue;
    logic [PCW:0]      pc;
    logic              busy;
    logic              finished;

    modport master (
`ifdef SEQ_LOOP_EN
        input  loop_cnt,
`endif
        input  prog_we, prog_addr, prog_data, prog_len, start, abort, done,
        output instr, reg1, reg2, reg3, cnst, issue, pc, busy, finished
    );

    modport slave (
`ifdef SEQ_LOOP_EN
        output loop_cnt,
`endif
        output prog_we, prog_addr, prog_data, prog_len, start, abort, done,
        input  instr, reg1, reg2, reg3, cnst, issue, pc, busy, finished
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Loadable program memory issuing instruction words to a processor,
//            paced on its done handshake. Define SEQ_LOOP_EN for repeat passes.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int OPW    = 3,
    parameter int REGW   = 5,
    parameter int CONSTW = 16,
    parameter int PCW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_sequencer_if.master    bus
);
    localparam int c_IW = OPW + 3*REGW + CONSTW;
    localparam int c_DEPTH = 2**PCW;
    localparam logic [PCW:0] c_DEPTH_V = {1'b1, {PCW{1'b0}}};
    localparam logic [PCW:0] c_ONE     = {{PCW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DRAIN    = 3'd3,
        S_FIN      = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [c_IW-1:0]   r_mem [c_DEPTH];
    logic [PCW:0]      r_pc;
    logic [PCW:0]      r_len;
    logic [OPW-1:0]    r_op;
    logic [REGW-1:0]   r_reg1;
    logic [REGW-1:0]   r_reg2;
    logic [REGW-1:0]   r_reg3;
    logic [CONSTW-1:0] r_imm;
    logic              r_issue;
    logic              r_finished;
`ifdef SEQ_LOOP_EN
    logic [7:0]        r_loops;
`endif

    logic              w_load;
    logic              w_issue;
    logic              w_rewind;
    logic              w_fin;
    logic [PCW:0]      w_len_clamped;
    logic [c_IW-1:0]   w_word;

    assign w_len_clamped = (bus.prog_len > c_DEPTH_V) ? c_DEPTH_V : bus.prog_len;
    assign w_word        = r_mem[r_pc[PCW-1:0]];

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        w_rewind     = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = (w_len_clamped == '0) ? S_FIN : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (bus.done) begin
                    w_issue      = 1'b1;
                    w_next_state = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // done low means the processor has taken the issued word
                if (!bus.done) begin
                    if (r_pc < r_len) begin
                        w_next_state = S_WAIT_RDY;
                    end
`ifdef SEQ_LOOP_EN
                    else if (r_loops != 8'd0) begin
                        w_rewind     = 1'b1;
                        w_next_state = S_WAIT_RDY;
                    end
`endif
                    else begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.done) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN: begin
                w_fin        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (bus.abort) begin
            w_next_state = S_IDLE;
            w_load       = 1'b0;
            w_issue      = 1'b0;
            w_rewind     = 1'b0;
            w_fin        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Program store is deliberately outside the reset domain so it survives rst
    always_ff @(posedge clk) begin
        if (bus.prog_we && (r_state == S_IDLE)) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_len      <= '0;
            r_op       <= '0;
            r_reg1     <= '0;
            r_reg2     <= '0;
            r_reg3     <= '0;
            r_imm      <= '0;
            r_issue    <= 1'b0;
            r_finished <= 1'b0;
`ifdef SEQ_LOOP_EN
            r_loops    <= 8'd0;
`endif
        end else begin
            r_issue    <= w_issue;
            r_finished <= w_fin;
            if (w_load) begin
                r_pc    <= '0;
                r_len   <= w_len_clamped;
`ifdef SEQ_LOOP_EN
                r_loops <= bus.loop_cnt;
`endif
            end else if (w_issue) begin
                r_pc <= r_pc + c_ONE;
                {r_op, r_reg1, r_reg2, r_reg3, r_imm} <= w_word;
            end else if (w_rewind) begin
                r_pc    <= '0;
`ifdef SEQ_LOOP_EN
                r_loops <= r_loops - 8'd1;
`endif
            end
        end
    end

    assign bus.instr    = r_op;
    assign bus.reg1     = r_reg1;
    assign bus.reg2     = r_reg2;
    assign bus.reg3     = r_reg3;
    assign bus.cnst     = r_imm;
    assign bus.issue    = r_issue;
    assign bus.pc       = r_pc;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.finished = r_finished;

endmodule
`default_nettype wire
